// File: rtl/cdc_pkg.sv
// Shared definitions for the clock-domain-crossing receivers.
package cdc_pkg;

  typedef enum logic {
    ST_PRIME,
    ST_RUN
  } edge_rx_state_t;

  localparam int CDC_MIN_SYNC_STAGES = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop level synchroniser for a single asynchronous bit.
module bit_synchronizer
  import cdc_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  if (STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_stages
    $error("bit_synchronizer: STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
  end

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/edge_to_pulse.sv
// Toggle-encoded CDC receiver: each input transition becomes one pulse and
// one entry in a saturating pending-event counter drained by valid/ready.
module edge_to_pulse
  import cdc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter bit ACTIVE_LOW  = 1'b0,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             signal,
  output logic             pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  input  logic             clear
);

  if (SYNC_STAGES < CDC_MIN_SYNC_STAGES) begin : g_bad_sync
    $error("edge_to_pulse: SYNC_STAGES must be at least %0d", CDC_MIN_SYNC_STAGES);
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("edge_to_pulse: CNT_W must be at least 1");
  end

  localparam int              PW         = $clog2(SYNC_STAGES + 1) + 1;
  localparam logic [PW-1:0]   PRIME_LAST = PW'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync_q;
  logic             prev_q;
  logic             edge_raw;
  logic             evt;
  logic             pop;
  edge_rx_state_t   state_reg, state_next;
  logic [PW-1:0]    prime_reg, prime_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             overflow_reg, overflow_next;
  logic             pulse_reg;

  bit_synchronizer #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (signal),
    .q       (sync_q)
  );

  assign edge_raw  = sync_q ^ prev_q;
  assign evt       = edge_raw && (state_reg == ST_RUN);
  assign evt_valid = (count_reg != '0);
  assign pop       = evt_valid && evt_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= 1'b0;
      state_reg    <= ST_PRIME;
      prime_reg    <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
      pulse_reg    <= ACTIVE_LOW;
    end else begin
      prev_q       <= sync_q;
      state_reg    <= state_next;
      prime_reg    <= prime_next;
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
      pulse_reg    <= evt ^ ACTIVE_LOW;
    end
  end

  // Priming waits for the synchroniser and prev_q to hold the settled input
  // level, so a source already at 1 when reset releases is not an event.
  always_comb begin
    state_next = state_reg;
    prime_next = prime_reg;
    case (state_reg)
      ST_PRIME: begin
        if (prime_reg == PRIME_LAST) begin
          state_next = ST_RUN;
        end else begin
          prime_next = prime_reg + 1'b1;
        end
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_PRIME;
    endcase
  end

  always_comb begin
    count_next    = count_reg;
    overflow_next = overflow_reg;
    if (clear) begin
      count_next    = '0;
      overflow_next = 1'b0;
    end else if (evt && pop) begin
      count_next = count_reg;
    end else if (evt) begin
      if (count_reg != CNT_MAX) begin
        count_next = count_reg + 1'b1;
      end else begin
        overflow_next = 1'b1;
      end
    end else if (pop) begin
      count_next = count_reg - 1'b1;
    end
  end

  assign pulse     = pulse_reg;
  assign evt_count = count_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_edge_to_pulse.sv
// Self-checking bench: two polarities of edge_to_pulse share one stimulus and
// are compared every cycle against a sample-history model of the receiver.
module tb_edge_to_pulse;
  import cdc_pkg::*;

  localparam int S    = 2;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          signal = 1'b0;
  logic          evt_ready = 1'b0;
  logic          clear = 1'b0;
  logic          pulse_a, pulse_b;
  logic          valid_a, valid_b;
  logic          ovf_a, ovf_b;
  logic [CW-1:0] count_a, count_b;

  int n_checks = 0;
  int n_fail   = 0;
  int pulses_seen = 0;

  edge_to_pulse #(.SYNC_STAGES(S), .ACTIVE_LOW(1'b0), .CNT_W(CW)) dut_a (
    .clk(clk), .reset_n(reset_n), .signal(signal), .pulse(pulse_a),
    .evt_valid(valid_a), .evt_ready(evt_ready), .evt_count(count_a),
    .overflow(ovf_a), .clear(clear)
  );

  edge_to_pulse #(.SYNC_STAGES(S), .ACTIVE_LOW(1'b1), .CNT_W(CW)) dut_b (
    .clk(clk), .reset_n(reset_n), .signal(signal), .pulse(pulse_b),
    .evt_valid(valid_b), .evt_ready(evt_ready), .evt_count(count_b),
    .overflow(ovf_b), .clear(clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the input level sampled at every clock edge since reset
  // release. The event reported after edge n is a change between the samples
  // taken S and S+1 edges earlier, ignored until priming has completed.
  initial begin
    bit hist[$];
    int edge_n;
    int m_cnt;
    bit m_ovf, m_pulse, ev, pop, sig, rdy, clr, rst;
    hist = {1'b0};
    edge_n = 0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
    forever begin
      @(posedge clk);
      sig = signal; rdy = evt_ready; clr = clear; rst = reset_n;
      if (!rst) begin
        hist = {1'b0};
        edge_n = 0; m_cnt = 0; m_ovf = 0; m_pulse = 0;
      end else begin
        edge_n++;
        hist.push_back(sig);
        ev  = (edge_n >= S + 2) && (hist[edge_n-S] != hist[edge_n-S-1]);
        pop = (m_cnt != 0) && rdy;
        if (clr) begin
          m_cnt = 0;
          m_ovf = 0;
        end else if (ev && pop) begin
          m_cnt = m_cnt;
        end else if (ev) begin
          if (m_cnt < CMAX) m_cnt++;
          else m_ovf = 1;
        end else if (pop) begin
          m_cnt--;
        end
        m_pulse = ev;
      end
      #1;
      check("pulse_hi", int'(pulse_a), int'(m_pulse));
      check("pulse_lo", int'(pulse_b), int'(!m_pulse));
      check("count_a", int'(count_a), m_cnt);
      check("count_b", int'(count_b), m_cnt);
      check("valid", int'(valid_a), int'(m_cnt != 0));
      check("overflow", int'(ovf_a), int'(m_ovf));
      check("overflow_b", int'(ovf_b), int'(m_ovf));
      pulses_seen += int'(pulse_a);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pulse_hi"}, int'(pulse_a), 0);
    check({tag, "_pulse_lo"}, int'(pulse_b), 1);
    check({tag, "_count"}, int'(count_a), 0);
    check({tag, "_valid"}, int'(valid_a), 0);
    check({tag, "_overflow"}, int'(ovf_a), 0);
    check({tag, "_state"}, int'(dut_a.state_reg), int'(ST_PRIME));
  endtask

  task automatic check_priming(input string tag);
    reset_n = 1'b1;
    cyc(1);
    check({tag, "_prime_e1"}, int'(dut_a.state_reg), int'(ST_PRIME));
    cyc(1);
    check({tag, "_prime_e2"}, int'(dut_a.state_reg), int'(ST_PRIME));
    cyc(1);
    check({tag, "_run_e3"}, int'(dut_a.state_reg), int'(ST_RUN));
  endtask

  initial begin
    int p0;
    int last;

    // Reset with the source level already high.
    signal = 1'b1;
    reset_n = 1'b0;
    cyc(3);
    check_reset_values("rst");
    p0 = pulses_seen;
    check_priming("rst");
    cyc(10);
    check("rst_no_pulse", pulses_seen - p0, 0);
    check("rst_count", int'(count_a), 0);

    // Single toggle: pulse only in the cycle after edge 2.
    signal = ~signal;
    cyc(1);
    check("single_e0", int'(pulse_a), 0);
    cyc(1);
    check("single_e1", int'(pulse_a), 0);
    cyc(1);
    check("single_e2_hi", int'(pulse_a), 1);
    check("single_e2_lo", int'(pulse_b), 0);
    check("single_count", int'(count_a), 1);
    check("single_valid", int'(valid_a), 1);
    cyc(1);
    check("single_e3", int'(pulse_a), 0);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("single_pop", int'(count_a), 0);
    check("single_pop_valid", int'(valid_a), 0);

    // Saturation with the consumer stalled, then clear.
    p0 = pulses_seen;
    repeat (17) begin
      signal = ~signal;
      cyc(3);
    end
    cyc(4);
    check("sat_count", int'(count_a), 15);
    check("sat_overflow", int'(ovf_a), 1);
    check("sat_pulses", pulses_seen - p0, 17);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    check("clr_count", int'(count_a), 0);
    check("clr_overflow", int'(ovf_a), 0);

    // Event coinciding with a pop at full count.
    repeat (15) begin
      signal = ~signal;
      cyc(3);
    end
    cyc(4);
    check("fill_count", int'(count_a), 15);
    signal = ~signal;
    cyc(2);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("evtpop_count", int'(count_a), 15);
    check("evtpop_overflow", int'(ovf_a), 0);
    evt_ready = 1'b1;
    cyc(1);
    evt_ready = 1'b0;
    check("pop_only", int'(count_a), 14);

    // Asynchronous reset in the middle of a cycle with events pending.
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    repeat (5) begin
      signal = ~signal;
      cyc(3);
    end
    cyc(4);
    check("burst_count", int'(count_a), 5);
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    cyc(2);
    p0 = pulses_seen;
    check_priming("midrst");
    cyc(6);
    check("midrst_no_pulse", pulses_seen - p0, 0);

    // Randomised traffic: sparse reads first to reach saturation, then
    // busier reads, with occasional clears and one reset.
    last = 0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      last++;
      if (last >= 2 && $urandom_range(0, 2) == 0) begin
        signal = ~signal;
        last = 0;
      end
      if (i < 750) evt_ready = ($urandom_range(0, 5) == 0);
      else         evt_ready = ($urandom_range(0, 1) == 0);
      clear = ($urandom_range(0, 99) == 0);
      if (i == 1000) reset_n = 1'b0;
      if (i == 1004) reset_n = 1'b1;
    end
    @(negedge clk);
    clear = 1'b0;
    evt_ready = 1'b0;
    cyc(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_to_pulse.md
# edge_to_pulse

Destination-domain receiver for toggle-encoded clock-domain crossings. It takes a level that flips once per source event from a source-domain toggle generator and synchronises it into `clk`. Each transition becomes one single-cycle pulse. Events are also counted in a saturating pending counter that a consumer drains through a valid/ready handshake, so bursts are not lost when the consumer stalls.

## Interface
Parameters:
- `SYNC_STAGES`, 2, synchroniser depth; legal range ≥2.
- `ACTIVE_LOW`, 0, polarity of `pulse`; 1 means `pulse` idles high and pulses low.
- `CNT_W`, 4, width of the pending-event counter; legal range ≥1.

Ports:
- `clk`  in  1  destination-domain clock; one clock only.
- `reset_n`  in  1  reset, asynchronous and active-low.
- `signal`  in  1  asynchronous toggle input; each transition is one event.
- `pulse`  out  1  one-cycle event strobe, registered; polarity set by `ACTIVE_LOW`.
- `evt_valid`  out  1  high when `evt_count` != 0.
- `evt_ready`  in  1  consumer accepts one event when `evt_valid` && `evt_ready`.
- `evt_count`  out  CNT_W  number of pending events.
- `overflow`  out  1  sticky flag; an event was dropped at saturation.
- `clear`  in  1  synchronous; zeroes `evt_count` and `overflow`.

## Operation
- **Synchroniser:** `signal` passes through `SYNC_STAGES` flops, all reset to 0. `sync_q` is the last stage. `prev_q` holds `sync_q` delayed by one cycle and resets to 0.
- **Raw edge:** `edge_raw` = `sync_q` ^ `prev_q`. Both rising and falling transitions count.
- **State machine:**
  - `ST_PRIME` is the reset state. A prime counter counts `SYNC_STAGES`+1 rising edges, then the block moves to `ST_RUN`.
  - In `ST_PRIME`, `prev_q` still tracks `sync_q`, but `edge_raw` is discarded. This suppresses a spurious event when the source level is 1 at reset release.
  - `ST_RUN` is terminal until reset.
- **Event:** `evt` = `edge_raw` && (state == `ST_RUN`).
- **Pulse output:** `pulse` is registered: `pulse` <= `evt` ^ `ACTIVE_LOW`.
- **Counter update, in priority order:**
  1. `clear`: count <= 0 and `overflow` <= 0. Any `evt` or pop in the same cycle is discarded; `pulse` is still generated.
  2. `evt` && pop: count unchanged. `overflow` does not set, even at max.
  3. `evt` only, count < 2^CNT_W−1: count + 1.
  4. `evt` only, count == max: count unchanged, `overflow` <= 1.
  5. pop only: count − 1.
- **Pop rules:** a pop is `evt_valid` && `evt_ready`. `evt_ready` while the count is 0 has no effect, and the count never underflows.
- **Width rules:** all counter arithmetic is in `CNT_W` bits, with explicit saturation and no wrap-around.

## Timing
- **Reset values:** `pulse` = `ACTIVE_LOW`, `evt_valid` = 0, `evt_count` = 0, `overflow` = 0, state = `ST_PRIME`, sync flops = 0, `prev_q` = 0.
- **Latency:** let the input transition meet setup before rising edge 0 in `ST_RUN`. Then `pulse` is active in the cycle following edge `SYNC_STAGES`, and `evt_count` increments on that same edge.
- **Pulse width:** exactly one cycle per transition. Back-to-back transitions, one per cycle after synchronisation, produce back-to-back pulses.
- **Input spacing:** source transitions must be ≥2 `clk` periods apart. Closer spacing may merge events; this is the upstream constraint.
- **Prime window:** transitions landing in `sync_q` during `ST_PRIME` are absorbed without a pulse or count.
- **Reset mid-operation:** asserting `reset_n` low immediately forces all reset values. Pending events are lost and priming restarts.
- **Handshake timing:** `evt_valid` is combinational from the count register. A pop decrements on the same rising edge where valid && ready is sampled.

## Structure
- The shared package `cdc_pkg` holds:
  - the typedef enum logic `edge_rx_state_t` {`ST_PRIME`, `ST_RUN`};
  - the constant `CDC_MIN_SYNC_STAGES` = 2.
- The sub-module `bit_synchronizer` (parameter `STAGES`; ports `clk`, `reset_n`, `d`, `q`) implements the synchroniser chain. It is reusable elsewhere and is the only place synthesis attributes for async registers are applied.
- Parameter checks are elaboration-time assertions: `SYNC_STAGES` ≥ `CDC_MIN_SYNC_STAGES` and `CNT_W` ≥ 1.

## Test plan
- **Reset with `signal` = 1:** hold `signal` = 1 through reset, release, wait 10 cycles. Expect no `pulse`, `evt_count` = 0, state `ST_RUN` after 3 edges (`SYNC_STAGES` = 2).
- **Single toggle:** in `ST_RUN`, toggle `signal` 0→1 before edge 0. Expect `pulse` active only in the cycle after edge 2, then `evt_count` = 1 and `evt_valid` = 1. Pulse `evt_ready` for one cycle and expect `evt_count` = 0.
- **Saturation:** with `CNT_W` = 4 and `evt_ready` = 0, apply 17 toggles spaced 3 cycles apart. Expect `evt_count` = 15, `overflow` = 1, and 17 pulses. Assert `clear` and expect `evt_count` = 0, `overflow` = 0.
- **Simultaneous event and pop:** with the count at 15 and `evt_ready` = 1, coincide an event with the pop. Expect the count to stay at 15 and `overflow` to stay 0.
- **Active-low polarity:** with `ACTIVE_LOW` = 1, expect `pulse` = 1 in reset and idle, and `pulse` = 0 for exactly one cycle per toggle.
- **Reset during burst:** hold `evt_count` = 5 and assert `reset_n` low mid-cycle. Expect all outputs at reset values immediately and the priming sequence repeated.
